// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer
// Keypad-to-operand entry stage. Each rising edge of the keypad strobe is one
// press. The press is decoded into a signed 3-digit BCD entry: digits enter at
// the least-significant end, the sign toggles, and backspace is supported.
//
// Optional build macro: DIGIT_ENTRY_KEY_SYNC_EN
//   defined     - keyValid/keyCode pass through a two-flop synchronizer before
//                 press detection (press latency N+2)
//   not defined - keyValid/keyCode are used directly (keypad synchronous to Clock)
//
// Count states (derived from digitCount):
//   state       | meaning
//   ST_EMPTY    | no significant digits held (count = 0)
//   ST_ENTERING | 0 < count < MAX_DIGITS
//   ST_FULL     | count = MAX_DIGITS, further digits are rejected
module digit_entry_buffer #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  input  logic       entryClear,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       isNegative,
  output logic [1:0] digitCount,
  output logic       keyAccepted,
  output logic       keyRejected
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ENTERING = 2'd1,
    ST_FULL     = 2'd2
  } count_state_e;

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  logic       kv_in;
  logic [3:0] kc_in;

  logic       prev_q, prev_d;
  logic [3:0] dig1_q, dig1_d;
  logic [3:0] dig2_q, dig2_d;
  logic [3:0] dig3_q, dig3_d;
  logic       neg_q, neg_d;
  logic [1:0] cnt_q, cnt_d;
  logic       acc_q, acc_d;
  logic       rej_q, rej_d;

  logic         press;
  count_state_e state;

`ifdef DIGIT_ENTRY_KEY_SYNC_EN
  logic       kv_s1_q, kv_s1_d;
  logic       kv_s2_q, kv_s2_d;
  logic [3:0] kc_s1_q, kc_s1_d;
  logic [3:0] kc_s2_q, kc_s2_d;

  // two-stage synchronizer next-state for the asynchronous keypad inputs
  always_comb begin
    kv_s1_d = keyValid;
    kv_s2_d = kv_s1_q;
    kc_s1_d = keyCode;
    kc_s2_d = kc_s1_q;
  end

  // synchronizer flops, cleared by reset
  always_ff @(posedge Clock) begin
    if (reset) begin
      kv_s1_q <= 1'b0;
      kv_s2_q <= 1'b0;
      kc_s1_q <= 4'h0;
      kc_s2_q <= 4'h0;
    end else begin
      kv_s1_q <= kv_s1_d;
      kv_s2_q <= kv_s2_d;
      kc_s1_q <= kc_s1_d;
      kc_s2_q <= kc_s2_d;
    end
  end

  assign kv_in = kv_s2_q;
  assign kc_in = kc_s2_q;
`else
  assign kv_in = keyValid;
  assign kc_in = keyCode;
`endif

  assign press = kv_in & ~prev_q;

  // classify the held digit count
  always_comb begin
    if (cnt_q == 2'd0) begin
      state = ST_EMPTY;
    end else if (cnt_q >= MAX_CNT) begin
      state = ST_FULL;
    end else begin
      state = ST_ENTERING;
    end
  end

  // key decode and buffer next-state; a clear request discards any press
  always_comb begin
    prev_d = kv_in;
    dig1_d = dig1_q;
    dig2_d = dig2_q;
    dig3_d = dig3_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    acc_d  = 1'b0;
    rej_d  = 1'b0;

    if (entryClear) begin
      dig1_d = 4'h0;
      dig2_d = 4'h0;
      dig3_d = 4'h0;
      neg_d  = 1'b0;
      cnt_d  = 2'd0;
    end else if (press) begin
      if (kc_in <= 4'd9) begin
        if (state == ST_FULL) begin
          rej_d = 1'b1;
        end else if ((state == ST_EMPTY) && (kc_in == 4'd0)) begin
          // leading zero adds no significant digit
          acc_d = 1'b1;
        end else begin
          dig3_d = dig2_q;
          dig2_d = dig1_q;
          dig1_d = kc_in;
          cnt_d  = cnt_q + 2'd1;
          acc_d  = 1'b1;
        end
      end else begin
        case (kc_in)
          KEY_SIGN: begin
            neg_d = ~neg_q;
            acc_d = 1'b1;
          end
          KEY_BACK: begin
            if (state == ST_EMPTY) begin
              neg_d = 1'b0;
            end else begin
              dig1_d = dig2_q;
              dig2_d = dig3_q;
              dig3_d = 4'h0;
              cnt_d  = cnt_q - 2'd1;
            end
            acc_d = 1'b1;
          end
          KEY_CLEAR: begin
            dig1_d = 4'h0;
            dig2_d = 4'h0;
            dig3_d = 4'h0;
            neg_d  = 1'b0;
            cnt_d  = 2'd0;
            acc_d  = 1'b1;
          end
          default: begin
            rej_d = 1'b1;
          end
        endcase
      end
    end

    // positions beyond MAX_DIGITS never hold a digit
    if (MAX_DIGITS < 3) begin
      dig3_d = 4'h0;
    end
    if (MAX_DIGITS < 2) begin
      dig2_d = 4'h0;
    end
  end

  // buffer registers; reset overrides clear and any pending press
  always_ff @(posedge Clock) begin
    if (reset) begin
      prev_q <= 1'b0;
      dig1_q <= 4'h0;
      dig2_q <= 4'h0;
      dig3_q <= 4'h0;
      neg_q  <= 1'b0;
      cnt_q  <= 2'd0;
      acc_q  <= 1'b0;
      rej_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      dig1_q <= dig1_d;
      dig2_q <= dig2_d;
      dig3_q <= dig3_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      rej_q  <= rej_d;
    end
  end

  assign digit1      = dig1_q;
  assign digit2      = dig2_q;
  assign digit3      = dig3_q;
  assign isNegative  = neg_q;
  assign digitCount  = cnt_q;
  assign keyAccepted = acc_q;
  assign keyRejected = rej_q;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: per-cycle vector table for the direct-input
// build, hand sequences for synchronizer latency and mid-entry reset.
module tb_digit_entry_buffer;

  logic       Clock;
  logic       reset;
  logic       keyValid;
  logic [3:0] keyCode;
  logic       entryClear;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       isNegative;
  logic [1:0] digitCount;
  logic       keyAccepted;
  logic       keyRejected;

  int checks = 0;
  int errors = 0;

  digit_entry_buffer #(.MAX_DIGITS(3)) dut (
    .Clock      (Clock),
    .reset      (reset),
    .keyValid   (keyValid),
    .keyCode    (keyCode),
    .entryClear (entryClear),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .isNegative (isNegative),
    .digitCount (digitCount),
    .keyAccepted(keyAccepted),
    .keyRejected(keyRejected)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst;
    logic       kv;
    logic [3:0] kc;
    logic       ec;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic       neg;
    logic [1:0] cnt;
    logic       acc;
    logic       rej;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic kv, input logic [3:0] kc,
                              input logic ec, input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic neg, input logic [1:0] cnt,
                              input logic acc, input logic rej);
    vec_t v;
    v.rst = rst; v.kv = kv; v.kc = kc; v.ec = ec;
    v.d3 = d3; v.d2 = d2; v.d1 = d1; v.neg = neg; v.cnt = cnt;
    v.acc = acc; v.rej = rej;
    vecs.push_back(v);
  endfunction

  function automatic logic [16:0] outs();
    return {digit3, digit2, digit1, isNegative, digitCount, keyAccepted, keyRejected};
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got d3d2d1=%h%h%h neg=%0b cnt=%0d acc=%0b rej=%0b want d3d2d1=%h%h%h neg=%0b cnt=%0d acc=%0b rej=%0b",
               name, got[16:13], got[12:9], got[8:5], got[4], got[3:2], got[1], got[0],
               want[16:13], want[12:9], want[8:5], want[4], want[3:2], want[1], want[0]);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    keyValid = 1'b0;
    keyCode = 4'h0;
    entryClear = 1'b0;
    #2;

`ifndef DIGIT_ENTRY_KEY_SYNC_EN
    //  rst kv kc    ec  d3    d2    d1    neg cnt  acc rej
    add(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0); // reset state
    add(0, 1, 4'h1, 0, 4'h0, 4'h0, 4'h1, 0, 2'd1, 1, 0);
    add(0, 0, 4'h1, 0, 4'h0, 4'h0, 4'h1, 0, 2'd1, 0, 0);
    add(0, 1, 4'h2, 0, 4'h0, 4'h1, 4'h2, 0, 2'd2, 1, 0);
    add(0, 0, 4'h2, 0, 4'h0, 4'h1, 4'h2, 0, 2'd2, 0, 0);
    add(0, 1, 4'h3, 0, 4'h1, 4'h2, 4'h3, 0, 2'd3, 1, 0);
    add(0, 0, 4'h3, 0, 4'h1, 4'h2, 4'h3, 0, 2'd3, 0, 0);
    add(0, 1, 4'h7, 0, 4'h1, 4'h2, 4'h3, 0, 2'd3, 0, 1); // digit while full
    add(0, 0, 4'h7, 0, 4'h1, 4'h2, 4'h3, 0, 2'd3, 0, 0);
    add(0, 1, 4'hA, 0, 4'h1, 4'h2, 4'h3, 1, 2'd3, 1, 0); // sign while full
    add(0, 0, 4'hA, 0, 4'h1, 4'h2, 4'h3, 1, 2'd3, 0, 0);
    add(0, 1, 4'hC, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 1, 0); // clear entry key
    add(0, 0, 4'hC, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 1, 0); // leading zeros
    add(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 1, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 1, 4'h5, 0, 4'h0, 4'h0, 4'h5, 0, 2'd1, 1, 0);
    add(0, 0, 4'h5, 0, 4'h0, 4'h0, 4'h5, 0, 2'd1, 0, 0);
    add(0, 0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0); // entryClear
    add(0, 1, 4'h4, 0, 4'h0, 4'h0, 4'h4, 0, 2'd1, 1, 0);
    add(0, 0, 4'h4, 0, 4'h0, 4'h0, 4'h4, 0, 2'd1, 0, 0);
    add(0, 1, 4'h2, 0, 4'h0, 4'h4, 4'h2, 0, 2'd2, 1, 0);
    add(0, 0, 4'h2, 0, 4'h0, 4'h4, 4'h2, 0, 2'd2, 0, 0);
    add(0, 1, 4'hB, 0, 4'h0, 4'h0, 4'h4, 0, 2'd1, 1, 0); // backspace
    add(0, 0, 4'hB, 0, 4'h0, 4'h0, 4'h4, 0, 2'd1, 0, 0);
    add(0, 1, 4'hB, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 1, 0);
    add(0, 0, 4'hB, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 1, 4'hA, 0, 4'h0, 4'h0, 4'h0, 1, 2'd0, 1, 0);
    add(0, 0, 4'hA, 0, 4'h0, 4'h0, 4'h0, 1, 2'd0, 0, 0);
    add(0, 1, 4'hB, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 1, 0); // backspace empty clears sign
    add(0, 0, 4'hB, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 1, 4'hA, 0, 4'h0, 4'h0, 4'h0, 1, 2'd0, 1, 0);
    add(0, 0, 4'hA, 0, 4'h0, 4'h0, 4'h0, 1, 2'd0, 0, 0);
    add(0, 1, 4'h9, 0, 4'h0, 4'h0, 4'h9, 1, 2'd1, 1, 0);
    add(0, 0, 4'h9, 0, 4'h0, 4'h0, 4'h9, 1, 2'd1, 0, 0);
    add(0, 1, 4'h3, 1, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0); // clear beats press
    add(0, 1, 4'h3, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0); // held, no re-fire
    add(0, 1, 4'h3, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 0, 4'h3, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 1, 4'h6, 0, 4'h0, 4'h0, 4'h6, 0, 2'd1, 1, 0); // held 10 cycles
    for (int i = 0; i < 9; i++)
      add(0, 1, 4'h6, 0, 4'h0, 4'h0, 4'h6, 0, 2'd1, 0, 0);
    add(0, 0, 4'h6, 0, 4'h0, 4'h0, 4'h6, 0, 2'd1, 0, 0);
    add(0, 1, 4'hE, 0, 4'h0, 4'h0, 4'h6, 0, 2'd1, 0, 1); // invalid keys
    add(0, 0, 4'hE, 0, 4'h0, 4'h0, 4'h6, 0, 2'd1, 0, 0);
    add(0, 1, 4'hD, 0, 4'h0, 4'h0, 4'h6, 0, 2'd1, 0, 1);
    add(0, 0, 4'hD, 0, 4'h0, 4'h0, 4'h6, 0, 2'd1, 0, 0);
    add(0, 1, 4'h1, 0, 4'h0, 4'h6, 4'h1, 0, 2'd2, 1, 0);
    add(0, 0, 4'h1, 0, 4'h0, 4'h6, 4'h1, 0, 2'd2, 0, 0);
    add(1, 1, 4'h5, 1, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0); // reset beats all
    add(1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);
    add(0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0, 0, 0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      keyValid = vecs[i].kv;
      keyCode = vecs[i].kc;
      entryClear = vecs[i].ec;
      step();
      check($sformatf("vec%0d", i), outs(),
            {vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].neg, vecs[i].cnt,
             vecs[i].acc, vecs[i].rej});
    end
`else
    step();
    step();
    check("sync_reset", outs(), 17'h0);
    reset = 1'b0;
    step();
    check("sync_idle", outs(), 17'h0);
    keyValid = 1'b1;
    keyCode = 4'h8;
    step();
    check("sync_k8_N", outs(), 17'h0);
    step();
    check("sync_k8_N1", outs(), 17'h0);
    step();
    check("sync_k8_N2", outs(), {4'h0, 4'h0, 4'h8, 1'b0, 2'd1, 1'b1, 1'b0});
    step();
    check("sync_k8_held", outs(), {4'h0, 4'h0, 4'h8, 1'b0, 2'd1, 1'b0, 1'b0});
    keyValid = 1'b0;
    step();
    step();
    step();
    check("sync_release", outs(), {4'h0, 4'h0, 4'h8, 1'b0, 2'd1, 1'b0, 1'b0});
    keyValid = 1'b1;
    keyCode = 4'h4;
    step();
    step();
    check("sync_k4_N1", outs(), {4'h0, 4'h0, 4'h8, 1'b0, 2'd1, 1'b0, 1'b0});
    step();
    check("sync_k4_N2", outs(), {4'h0, 4'h8, 4'h4, 1'b0, 2'd2, 1'b1, 1'b0});
    keyValid = 1'b0;
    step();
    step();
    check("sync_cnt2", outs(), {4'h0, 4'h8, 4'h4, 1'b0, 2'd2, 1'b0, 1'b0});
    reset = 1'b1;
    step();
    check("sync_mid_reset", outs(), 17'h0);
    reset = 1'b0;
    keyValid = 1'b1;
    keyCode = 4'hE;
    step();
    step();
    step();
    check("sync_kE", outs(), {4'h0, 4'h0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1});
    keyValid = 1'b0;
    entryClear = 1'b1;
    step();
    check("sync_clear", outs(), 17'h0);
    entryClear = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
